// File: rtl/hdb3_decode_if.sv
// Line-side bundle for the HDB3 decoder: the two mark rails in, the recovered
// NRZ stream, its valid flag and the line-code error pulse out.
interface hdb3_decode_if;
    logic BP;
    logic BN;
    logic data_out;
    logic data_valid;
    logic code_err;

    modport master (
        output BP,
        output BN,
        input  data_out,
        input  data_valid,
        input  code_err
    );

    modport slave (
        input  BP,
        input  BN,
        output data_out,
        output data_valid,
        output code_err
    );
endinterface

// File: rtl/hdb3_decode.sv
// HDB3 line decoder: removes B00V/000V substitutions with a fixed 4-edge latency.
// Optional line-code checking is compiled in with macro HDB3_ERR_CHK_EN.
module hdb3_decode (
    input  logic         clk,
    input  logic         rst_n,
    hdb3_decode_if.slave line
);

    logic       mark_p;
    logic       mark_n;
    logic       is_mark;
    logic       is_v;

    logic [3:0] sr_q, sr_d;
    logic       last_pol_q, last_pol_d;
    logic       first_mark_q, first_mark_d;
    logic [2:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;

    // BP=BN=1 is neither mark, so it falls through as a space.
    always_comb begin
        mark_p  = line.BP & ~line.BN;
        mark_n  = ~line.BP & line.BN;
        is_mark = mark_p | mark_n;
        is_v    = is_mark & first_mark_q & (mark_p == last_pol_q);
    end

    always_comb begin
        sr_d         = {sr_q[2:0], is_mark & ~is_v};
        last_pol_d   = last_pol_q;
        first_mark_d = first_mark_q | is_mark;
        cnt_d        = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
        valid_d      = (cnt_d == 3'd4);
        if (is_mark) begin
            last_pol_d = mark_p;
        end
        // A V cancels itself and the three symbols before it, the oldest of
        // which is about to move into sr[3]; zeroing the whole line covers all four.
        if (is_v) begin
            sr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q         <= '0;
            last_pol_q   <= 1'b0;
            first_mark_q <= 1'b0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            last_pol_q   <= last_pol_d;
            first_mark_q <= first_mark_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
        end
    end

    assign line.data_out   = sr_q[3];
    assign line.data_valid = valid_q;

`ifdef HDB3_ERR_CHK_EN
    logic       illegal;
    logic [2:0] zrun_q, zrun_d;
    logic       prev_v_seen_q, prev_v_seen_d;
    logic       prev_v_pol_q, prev_v_pol_d;
    logic       err_q, err_d;

    always_comb begin
        illegal       = line.BP & line.BN;
        zrun_d        = zrun_q;
        prev_v_seen_d = prev_v_seen_q | is_v;
        prev_v_pol_d  = prev_v_pol_q;
        if (is_mark) begin
            zrun_d = '0;
        end else if (zrun_q != 3'd7) begin
            zrun_d = zrun_q + 3'd1;
        end
        if (is_v) begin
            prev_v_pol_d = mark_p;
        end
        // The run error fires only on the transition into the fourth space.
        err_d = illegal
              | (~is_mark & (zrun_q == 3'd3))
              | (is_v & prev_v_seen_q & (prev_v_pol_q == mark_p));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zrun_q        <= '0;
            prev_v_seen_q <= 1'b0;
            prev_v_pol_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            zrun_q        <= zrun_d;
            prev_v_seen_q <= prev_v_seen_d;
            prev_v_pol_q  <= prev_v_pol_d;
            err_q         <= err_d;
        end
    end

    assign line.code_err = err_q;
`else
    assign line.code_err = 1'b0;
`endif

    // mark_n is only needed to build is_mark; keep it referenced for clarity.
    logic unused_ok;
    assign unused_ok = mark_n;

endmodule

// File: tb/tb_hdb3_decode.sv
// Scoreboard bench for hdb3_decode: a symbol-level reference model pushes the
// expected output of every sampling edge; a monitor pops and compares.
module tb_hdb3_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hdb3_decode_if dut_if ();

    hdb3_decode dut (
        .clk  (clk),
        .rst_n(rst_n),
        .line (dut_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dv;
        logic dout;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: symbols are +1 (P), -1 (N), 0 (space), 2 (illegal).
    int   k;
    bit   dec[$];
    int   last_pol;
    bit   seen_mark;
    int   prev_v;
    int   zrun;

    function automatic void model_reset();
        k         = 0;
        dec.delete();
        last_pol  = 0;
        seen_mark = 0;
        prev_v    = 0;
        zrun      = 0;
    endfunction

    function automatic void model_step(input int sym);
        bit   is_mark;
        bit   v;
        bit   err;
        exp_t e;
        is_mark = (sym == 1) || (sym == -1);
        v   = 0;
        err = 0;
        if (is_mark) begin
            if (seen_mark && sym == last_pol) v = 1;
            last_pol  = sym;
            seen_mark = 1;
            zrun      = 0;
        end else begin
            zrun++;
            if (zrun == 4) err = 1;
        end
        dec.push_back(is_mark && !v);
        if (v) begin
            for (int j = k - 3; j <= k; j++)
                if (j >= 0) dec[j] = 0;
            if (prev_v == sym) err = 1;
            prev_v = sym;
        end
        if (sym == 2) err = 1;
`ifndef HDB3_ERR_CHK_EN
        err = 0;
`endif
        e.dv   = (k >= 3);
        e.dout = (k >= 3) ? dec[k-3] : 1'b0;
        e.err  = err;
        exp_q.push_back(e);
        k++;
    endfunction

    task automatic drive(input int sym);
        dut_if.BP = (sym == 1) || (sym == 2);
        dut_if.BN = (sym == -1) || (sym == 2);
    endtask

    task automatic send(input int sym);
        @(negedge clk);
        drive(sym);
        model_step(sym);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (dut_if.data_out !== 1'b0 || dut_if.data_valid !== 1'b0 || dut_if.code_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got dv=%0b dout=%0b err=%0b, expected all 0",
                     name, dut_if.data_valid, dut_if.data_out, dut_if.code_err);
        end
    endtask

    task automatic release_reset(input int first_sym);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(first_sym);
        model_step(first_sym);
    endtask

    // Reset is asserted between edges so the zero check proves it is asynchronous.
    task automatic do_reset(input int first_sym);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clk);
        release_reset(first_sym);
    endtask

    task automatic send_list(input int syms[$]);
        foreach (syms[i]) send(syms[i]);
    endtask

    function automatic int rand_sym();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 35) return 1;
        if (r < 70) return -1;
        if (r < 95) return 0;
        return 2;
    endfunction

    // Monitor: one expected entry per sampling edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                check_zero("in_reset");
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: got an edge with no expected entry, required one");
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (dut_if.data_valid !== e.dv || dut_if.data_out !== e.dout || dut_if.code_err !== e.err) begin
                    n_bad++;
                    $display("FAIL edge_%0d: got dv=%0b dout=%0b err=%0b, expected dv=%0b dout=%0b err=%0b",
                             k - 1 - exp_q.size(), dut_if.data_valid, dut_if.data_out, dut_if.code_err,
                             e.dv, e.dout, e.err);
                end
            end
        end
    end

    initial begin
        dut_if.BP = 1'b0;
        dut_if.BN = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Alternating marks: no V, continuous ones after the pipeline fills.
        release_reset(1);
        for (int i = 1; i < 12; i++) send((i % 2 == 0) ? 1 : -1);

        // P then B00V.
        do_reset(1);
        send_list('{-1, 0, 0, -1});
        repeat (4) send(0);

        // First mark is N; only the second N is a V.
        do_reset(-1);
        send_list('{0, 0, 0, -1});
        repeat (4) send(1);

        // Illegal symbol, then a run of five spaces.
        send_list('{-1, 2, 1, -1, 0, 0, 0, 0, 0, 1});

        // Back-to-back 000V.
        send_list('{-1, 0, 0, 0, -1, 0, 0, 0, -1, 1, -1});

        // Reset in the middle of B00V; the tail afterwards must not leak.
        send_list('{1, -1, 0});
        do_reset(0);
        send_list('{-1, 1, 0, 0, 1, -1, 1, -1, 0, 0, 0});

        // Randomised line symbols with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset(rand_sym());
            else
                send(rand_sym());
        end

        repeat (2) send(0);
        @(posedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
